// File: rtl/core_wb_pkg.sv
// core_wb_pkg: shared sizes, FSM state encoding and result bundle
// for the write-back controller.
package core_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;
  localparam int AW         = $clog2(REG_NUM);
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 4;
  localparam int SCW        = $clog2(STARVE_MAX) + 1;

  typedef enum logic {
    WB_ST_RUN   = 1'b0,
    WB_ST_DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/core_wb_fifo.sv
// core_wb_fifo: small synchronous FIFO for buffered LSU/MUL results.
// Head is read combinationally; DEPTH must be a power of two.
module core_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_wb_ctrl.sv
// core_wb_ctrl: sole regfile writer; ALU/LSU arbitration, starvation drain, busy scoreboard.
// Define CORE_WB_FWD_EN to add the early-forwarding outputs fwd_valid/fwd_addr/fwd_data.
module core_wb_ctrl
  import core_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wb_valid,
  input  logic [AW-1:0]      alu_wb_addr,
  input  logic [XLEN-1:0]    alu_wb_data,
  input  logic               lsu_wb_valid,
  output logic               lsu_wb_ready,
  input  logic [AW-1:0]      lsu_wb_addr,
  input  logic [XLEN-1:0]    lsu_wb_data,
  input  logic               sb_set_valid,
  input  logic [AW-1:0]      sb_set_addr,
  output logic [REG_NUM-1:0] sb_busy,
  output logic               wb_stall,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [XLEN-1:0]    rf_wdata
`ifdef CORE_WB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [AW-1:0]      fwd_addr,
  output logic [XLEN-1:0]    fwd_data
`endif
);

  wb_state_e          state;
  logic [SCW-1:0]     starve_cnt;
  wb_req_t            head;
  wb_req_t            lsu_req;
  wb_req_t            sel;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               sel_valid;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;

  assign lsu_wb_ready = !full;
  assign push         = lsu_wb_valid && !full;
  assign pop          = !alu_wb_valid && !empty;
  assign sel_valid    = alu_wb_valid || !empty;
  assign lsu_req      = '{addr: lsu_wb_addr, data: lsu_wb_data};

  core_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wb_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (lsu_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    sel = head;
    if (alu_wb_valid) begin
      sel = '{addr: alu_wb_addr, data: alu_wb_data};
    end
  end

`ifdef CORE_WB_FWD_EN
  assign fwd_valid = sel_valid && (sel.addr != '0);
  assign fwd_addr  = sel.addr;
  assign fwd_data  = sel.data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_valid && (sel.addr != '0);
      if (sel_valid) begin
        rf_waddr <= sel.addr;
        rf_wdata <= sel.data;
      end
    end
  end

  // Counts ALU wins that leave a buffered result waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WB_ST_RUN;
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      unique case (state)
        WB_ST_RUN: begin
          if (alu_wb_valid && !empty) begin
            if (starve_cnt == SCW'(STARVE_MAX - 1)) begin
              state      <= WB_ST_DRAIN;
              wb_stall   <= 1'b1;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        WB_ST_DRAIN: begin
          state      <= WB_ST_RUN;
          wb_stall   <= 1'b0;
          starve_cnt <= '0;
        end
        default: begin
          state      <= WB_ST_RUN;
          wb_stall   <= 1'b0;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Set is applied after clear so a coincident set keeps the bit busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (sb_set_valid) begin
      set_vec[sb_set_addr] = 1'b1;
    end
    if (pop) begin
      clr_vec[head.addr] = 1'b1;
    end
    set_vec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy <= '0;
    end else begin
      sb_busy <= (sb_busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_core_wb_ctrl.sv
// tb_core_wb_ctrl: directed scenarios plus randomized traffic against
// a queue-based model of the write-back controller.
module tb_core_wb_ctrl;
  import core_wb_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               alu_wb_valid;
  logic [AW-1:0]      alu_wb_addr;
  logic [XLEN-1:0]    alu_wb_data;
  logic               lsu_wb_valid;
  logic               lsu_wb_ready;
  logic [AW-1:0]      lsu_wb_addr;
  logic [XLEN-1:0]    lsu_wb_data;
  logic               sb_set_valid;
  logic [AW-1:0]      sb_set_addr;
  logic [REG_NUM-1:0] sb_busy;
  logic               wb_stall;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
`ifdef CORE_WB_FWD_EN
  logic               fwd_valid;
  logic [AW-1:0]      fwd_addr;
  logic [XLEN-1:0]    fwd_data;
`endif

  always #5 clk = ~clk;

  core_wb_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .sb_set_valid (sb_set_valid),
    .sb_set_addr  (sb_set_addr),
    .sb_busy      (sb_busy),
    .wb_stall     (wb_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
`ifdef CORE_WB_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  wb_req_t            q[$];
  logic [REG_NUM-1:0] m_busy;
  int                 streak;
  bit                 exp_we;
  bit                 exp_stall;
  bit                 exp_ready;
  logic [AW-1:0]      exp_addr;
  logic [XLEN-1:0]    exp_data;

  task automatic model_reset();
    q.delete();
    m_busy    = '0;
    streak    = 0;
    exp_we    = 0;
    exp_stall = 0;
    exp_ready = 1;
    exp_addr  = '0;
    exp_data  = '0;
  endtask

  task automatic idle();
    alu_wb_valid = 0;
    alu_wb_addr  = '0;
    alu_wb_data  = '0;
    lsu_wb_valid = 0;
    lsu_wb_addr  = '0;
    lsu_wb_data  = '0;
    sb_set_valid = 0;
    sb_set_addr  = '0;
  endtask

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic step();
    bit            nonempty;
    bit            room;
    bit            sel;
    bit            popped;
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    wb_req_t       e;
    nonempty = q.size() > 0;
    room     = q.size() < FIFO_DEPTH;
    sel      = 0;
    popped   = 0;
    a        = '0;
    d        = '0;
    if (alu_wb_valid) begin
      sel = 1; a = alu_wb_addr; d = alu_wb_data;
    end else if (nonempty) begin
      e = q.pop_front();
      sel = 1; popped = 1; a = e.addr; d = e.data;
    end
    if (lsu_wb_valid && room)
      q.push_back('{addr: lsu_wb_addr, data: lsu_wb_data});
    exp_stall = 0;
    if (alu_wb_valid && nonempty) begin
      streak++;
      if (streak == STARVE_MAX) begin
        exp_stall = 1;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
    if (popped && a != 0) m_busy[a] = 1'b0;
    if (sb_set_valid && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    exp_we = sel && (a != 0);
    if (exp_we) begin
      exp_addr = a;
      exp_data = d;
    end
    exp_ready = q.size() < FIFO_DEPTH;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #12;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
    total++; if (rf_waddr !== '0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
    total++; if (rf_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
    total++; if (lsu_wb_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", lsu_wb_ready); end
    total++; if (sb_busy !== '0) begin bad++; $display("FAIL reset_busy got=%h want=0", sb_busy); end
    total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", wb_stall); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_alu_basic();
    idle();
    alu_wb_valid = 1; alu_wb_addr = 5; alu_wb_data = 32'hDEADBEEF;
    step();
    idle();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", rf_we); end
    total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL alu_addr got=%0d want=5", rf_waddr); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%h want=deadbeef", rf_wdata); end
    step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_we_one_cycle got=%b want=0", rf_we); end
  endtask

  task automatic test_alu_lsu_collide();
    idle();
    alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 32'h1;
    lsu_wb_valid = 1; lsu_wb_addr = 7; lsu_wb_data = 32'h2;
    step();
    idle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1) begin
      bad++; $display("FAIL collide_alu got=%b/%0d/%h want=1/3/1", rf_we, rf_waddr, rf_wdata); end
    total++; if (lsu_wb_ready !== 1'b1) begin bad++; $display("FAIL collide_ready got=%b want=1", lsu_wb_ready); end
    step();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2) begin
      bad++; $display("FAIL collide_lsu got=%b/%0d/%h want=1/7/2", rf_we, rf_waddr, rf_wdata); end
    step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL collide_idle got=%b want=0", rf_we); end
  endtask

  task automatic test_starve();
    wb_req_t seq[3];
    int      first_stall;
    int      n_lsu;
    int      k_push;
    for (int k = 0; k < 3; k++) seq[k] = '{addr: AW'(11 + k), data: $urandom};
    first_stall = -1; n_lsu = 0; k_push = 0;
    idle();
    for (int i = 0; i < 40 && n_lsu < 3; i++) begin
      alu_wb_valid = !exp_stall;
      alu_wb_addr  = 10;
      alu_wb_data  = $urandom;
      lsu_wb_valid = (k_push < 3);
      if (k_push < 3) begin
        lsu_wb_addr = seq[k_push].addr;
        lsu_wb_data = seq[k_push].data;
        if (exp_ready) k_push++;
      end
      step();
      if (i == 1) begin
        total++; if (lsu_wb_ready !== 1'b0) begin bad++; $display("FAIL starve_full got=%b want=0", lsu_wb_ready); end
      end
      total++; if (wb_stall !== exp_stall) begin bad++; $display("FAIL starve_stall cyc=%0d got=%b want=%b", i, wb_stall, exp_stall); end
      if (wb_stall === 1'b1 && first_stall < 0) first_stall = i;
      if (rf_we === 1'b1 && rf_waddr !== 5'd10) begin
        if (n_lsu == 0) begin
          total++; if (i != 5) begin bad++; $display("FAIL starve_first_drain cyc got=%0d want=5", i); end
        end
        total++; if (rf_waddr !== seq[n_lsu].addr || rf_wdata !== seq[n_lsu].data) begin
          bad++; $display("FAIL starve_order got=%0d/%h want=%0d/%h", rf_waddr, rf_wdata, seq[n_lsu].addr, seq[n_lsu].data); end
        n_lsu++;
      end
    end
    total++; if (first_stall != 4) begin bad++; $display("FAIL starve_when got=%0d want=4", first_stall); end
    total++; if (n_lsu != 3) begin bad++; $display("FAIL starve_count got=%0d want=3", n_lsu); end
    drain();
  endtask

  task automatic test_scoreboard();
    logic [XLEN-1:0] d;
    d = $urandom;
    idle(); sb_set_valid = 1; sb_set_addr = 9; step();
    idle();
    total++; if (sb_busy[9] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b want=1", sb_busy[9]); end
    step();
    alu_wb_valid = 1; alu_wb_addr = 4; alu_wb_data = $urandom;
    lsu_wb_valid = 1; lsu_wb_addr = 9; lsu_wb_data = d;
    step();
    idle();
    total++; if (sb_busy[9] !== 1'b1) begin bad++; $display("FAIL sb_hold got=%b want=1", sb_busy[9]); end
    step();
    total++; if (sb_busy[9] !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b want=0", sb_busy[9]); end
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== d) begin
      bad++; $display("FAIL sb_write got=%b/%0d/%h want=1/9/%h", rf_we, rf_waddr, rf_wdata, d); end
    sb_set_valid = 1; sb_set_addr = 9; step();
    idle(); lsu_wb_valid = 1; lsu_wb_addr = 9; lsu_wb_data = $urandom; step();
    idle(); sb_set_valid = 1; sb_set_addr = 9; step();
    idle();
    total++; if (sb_busy[9] !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      bad++; $display("FAIL sb_set_wins got=%b/%b/%0d want=1/1/9", sb_busy[9], rf_we, rf_waddr); end
    lsu_wb_valid = 1; lsu_wb_addr = 9; lsu_wb_data = $urandom; step();
    idle(); step();
    total++; if (sb_busy !== m_busy || sb_busy[9] !== 1'b0) begin
      bad++; $display("FAIL sb_final got=%h want=%h", sb_busy, m_busy); end
  endtask

  task automatic test_x0();
    idle();
    alu_wb_valid = 1; alu_wb_addr = 0; alu_wb_data = $urandom;
    step();
    idle();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_alu got=%b want=0", rf_we); end
    total++; if (lsu_wb_ready !== 1'b1) begin bad++; $display("FAIL x0_ready_pre got=%b want=1", lsu_wb_ready); end
    lsu_wb_valid = 1; lsu_wb_addr = 0; lsu_wb_data = $urandom;
    sb_set_valid = 1; sb_set_addr = 0;
    step();
    idle();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_push got=%b want=0", rf_we); end
    step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_pop got=%b want=0", rf_we); end
    total++; if (sb_busy[0] !== 1'b0) begin bad++; $display("FAIL x0_busy got=%b want=0", sb_busy[0]); end
    step();
    total++; if (rf_we !== 1'b0 || lsu_wb_ready !== 1'b1) begin
      bad++; $display("FAIL x0_drained got=%b/%b want=0/1", rf_we, lsu_wb_ready); end
  endtask

  task automatic test_async_reset();
    idle();
    alu_wb_valid = 1; alu_wb_addr = 1; alu_wb_data = $urandom;
    lsu_wb_valid = 1; lsu_wb_addr = 20; lsu_wb_data = $urandom;
    step();
    alu_wb_addr = 2; lsu_wb_addr = 21; sb_set_valid = 1; sb_set_addr = 22;
    step();
    lsu_wb_valid = 0; alu_wb_addr = 3; sb_set_addr = 23;
    step();
    idle();
    total++; if (lsu_wb_ready !== 1'b0 || sb_busy[22] !== 1'b1 || rf_we !== 1'b1) begin
      bad++; $display("FAIL arst_pre got=%b/%b/%b want=0/1/1", lsu_wb_ready, sb_busy[22], rf_we); end
    #2;
    rst_n = 0;
    #1;
    model_reset();
    total++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      bad++; $display("FAIL arst_wb got=%b/%0d/%h want=0/0/0", rf_we, rf_waddr, rf_wdata); end
    total++; if (lsu_wb_ready !== 1'b1 || sb_busy !== '0 || wb_stall !== 1'b0) begin
      bad++; $display("FAIL arst_ctl got=%b/%h/%b want=1/0/0", lsu_wb_ready, sb_busy, wb_stall); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL arst_stale cyc=%0d got=%b want=0", i, rf_we); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_wb_valid = !exp_stall && ($urandom_range(0, 9) < 7);
      alu_wb_addr  = AW'($urandom);
      alu_wb_data  = $urandom;
      lsu_wb_valid = $urandom_range(0, 1);
      lsu_wb_addr  = AW'($urandom);
      lsu_wb_data  = $urandom;
      sb_set_valid = ($urandom_range(0, 9) < 3);
      sb_set_addr  = AW'($urandom);
      step();
      total++; if (rf_we !== exp_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b want=%b", i, rf_we, exp_we); end
      if (exp_we) begin
        total++; if (rf_waddr !== exp_addr || rf_wdata !== exp_data) begin
          bad++; $display("FAIL rnd_wr cyc=%0d got=%0d/%h want=%0d/%h", i, rf_waddr, rf_wdata, exp_addr, exp_data); end
      end
      total++; if (lsu_wb_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, lsu_wb_ready, exp_ready); end
      total++; if (wb_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", i, wb_stall, exp_stall); end
      total++; if (sb_busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%h want=%h", i, sb_busy, m_busy); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_lsu_collide();
    test_starve();
    test_scoreboard();
    test_x0();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
